// File: rtl/spi_cmd_seq.sv
// spi_cmd_seq: command sequencer in front of the SPI master.
// Host commands {rw, addr, data} are queued in a small FIFO and issued one at
// a time over spi_cmd_valid/spi_cmd_ready. A read waits for the end of the
// master's read-data phase and returns {addr, data} on the rsp_* port; if the
// read never completes, an error response is returned after RD_TIMEOUT cycles.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   host_valid/host_cmd/host_ready  command input, host_ready = FIFO not full
//   spi_cmd_valid/spi_cmd/spi_cmd_ready  command toward the SPI master
//   spi_read_valid/spi_read_data    read-data phase flag and shift buffer
//   rsp_valid/rsp_ready/rsp_addr/rsp_data/rsp_err  read response
//   fifo_level                   FIFO occupancy
//   busy                         FIFO non-empty or sequencer not idle
module spi_cmd_seq #(
    parameter int CMD_RW_FLAG    = 1,
    parameter int CMD_ADDR_WIDTH = 3,
    parameter int CMD_DATA_WIDTH = 8,
    parameter int CMD_WIDTH      = CMD_RW_FLAG + CMD_ADDR_WIDTH + CMD_DATA_WIDTH,
    parameter int FIFO_DEPTH     = 4,
    parameter int RD_TIMEOUT     = 1023
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             host_valid,
    input  logic [CMD_WIDTH-1:0]             host_cmd,
    output logic                             host_ready,
    output logic                             spi_cmd_valid,
    output logic [CMD_WIDTH-1:0]             spi_cmd,
    input  logic                             spi_cmd_ready,
    input  logic                             spi_read_valid,
    input  logic [CMD_DATA_WIDTH-1:0]        spi_read_data,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [CMD_ADDR_WIDTH-1:0]        rsp_addr,
    output logic [CMD_DATA_WIDTH-1:0]        rsp_data,
    output logic                             rsp_err,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
    output logic                             busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(RD_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT_RD = 2'd2;
    localparam logic [1:0] S_CAPTURE = 2'd3;

    logic [CMD_WIDTH-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr, rd_ptr;
    logic [LW-1:0]             level;
    logic [1:0]                state;
    logic [CMD_WIDTH-1:0]      cmd_q;
    logic [CMD_ADDR_WIDTH-1:0] rd_addr;
    logic [TW-1:0]             to_cnt;
    logic                      rv_d;
    logic                      push, pop, head_is_rd, rv_fall, to_hit;

    assign host_ready    = (level != LW'(FIFO_DEPTH));
    assign push          = host_valid && host_ready;
    assign pop           = (state == S_ISSUE) && spi_cmd_ready;
    // rw flag is the MSB; 0 means read
    assign head_is_rd    = ~mem[rd_ptr][CMD_WIDTH-1];
    assign rv_fall       = rv_d && !spi_read_valid;
    assign to_hit        = (to_cnt == TW'(RD_TIMEOUT));
    assign spi_cmd_valid = (state == S_ISSUE);
    assign spi_cmd       = cmd_q;
    assign fifo_level    = level;
    assign busy          = (level != '0) || (state != S_IDLE);

    // Storage needs no reset: entries are only read when level says valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= host_cmd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd_q     <= '0;
            rd_addr   <= '0;
            to_cnt    <= '0;
            rv_d      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rv_d <= spi_read_valid;
            // Response consumed; a new response set below cannot coincide
            // because reads do not issue while one is pending.
            if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    // A read behind a pending response would overwrite it,
                    // so only reads stall here; writes keep flowing.
                    if (level != '0 && !(head_is_rd && rsp_valid)) begin
                        cmd_q <= mem[rd_ptr];
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (spi_cmd_ready) begin
                        if (cmd_q[CMD_WIDTH-1]) begin
                            state <= S_IDLE;
                        end else begin
                            rd_addr <= cmd_q[CMD_DATA_WIDTH +: CMD_ADDR_WIDTH];
                            to_cnt  <= '0;
                            state   <= S_WAIT_RD;
                        end
                    end
                end
                S_WAIT_RD: begin
                    // Falling edge checked first so real data beats a
                    // coincident timeout.
                    if (rv_fall) begin
                        state <= S_CAPTURE;
                    end else if (to_hit) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        rsp_addr  <= rd_addr;
                        state     <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                default: begin // S_CAPTURE
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_data  <= spi_read_data;
                    rsp_addr  <= rd_addr;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
